// File: rtl/lsu.sv
// RV32I load/store unit: turns core loads/stores into word-aligned,
// byte-enabled memory transactions and extends load data for write-back.
module lsu #(
    parameter int DW  = 32,
    parameter int BEW = DW / 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           lsu_req_i,
    input  logic           lsu_we_i,
    input  logic [2:0]     func3_i,
    input  logic [DW-1:0]  addr_i,
    input  logic [DW-1:0]  wdata_i,
    output logic           stall_o,
    output logic           done_o,
    output logic [DW-1:0]  rdata_o,
    output logic           misaligned_o,
    output logic           mem_req_o,
    output logic           mem_we_o,
    output logic [DW-1:0]  mem_addr_o,
    output logic [DW-1:0]  mem_wdata_o,
    output logic [BEW-1:0] mem_be_o,
    input  logic           mem_gnt_i,
    input  logic           mem_rvalid_i,
    input  logic [DW-1:0]  mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_we;
    logic [2:0]      r_func3;
    logic [DW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            w_legal;
    logic            w_accept;
    logic [BEW-1:0]  w_be;
    logic [DW-1:0]   w_wdata;
    logic [DW-1:0]   w_shift;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [DW-1:0]   w_ext;

    // Legality: funct3 must exist for the direction, and the address must be
    // naturally aligned for the access size.
    always_comb begin
        w_legal = 1'b0;
        case (func3_i)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~addr_i[0];
            3'b010:  w_legal = (addr_i[1:0] == 2'b00);
            3'b100:  w_legal = ~lsu_we_i;
            3'b101:  w_legal = ~lsu_we_i & ~addr_i[0];
            default: w_legal = 1'b0;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && lsu_req_i && w_legal;

    // Byte enables and lane-replicated store data from the latched request.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        if (r_we) begin
            case (r_func3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << r_addr[1:0];
                    w_wdata = {4{r_wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {r_addr[1], 1'b0};
                    w_wdata = {2{r_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = r_wdata;
                end
            endcase
        end
    end

    // Lane selection and sign/zero extension of the returned word.
    always_comb begin
        w_shift = mem_rdata_i >> {r_addr[1:0], 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = r_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (r_func3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = mem_rdata_i;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Latch the request on acceptance; capture load data on response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_func3 <= 3'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= lsu_we_i;
                r_func3 <= func3_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
            end
            if (r_state == S_WAIT && mem_rvalid_i && !r_we)
                r_rdata <= w_ext;
        end
    end

    // Next state and outputs; memory payload is only driven while requesting.
    always_comb begin
        w_next       = r_state;
        stall_o      = 1'b0;
        done_o       = 1'b0;
        misaligned_o = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_be_o     = '0;
        case (r_state)
            S_IDLE: begin
                if (lsu_req_i) begin
                    if (w_legal) begin
                        stall_o = 1'b1;
                        w_next  = S_REQ;
                    end else begin
                        misaligned_o = 1'b1;
                    end
                end
            end
            S_REQ: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = r_we;
                mem_addr_o  = {r_addr[DW-1:2], 2'b00};
                mem_wdata_o = w_wdata;
                mem_be_o    = w_be;
                if (mem_gnt_i) w_next = S_WAIT;
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (mem_rvalid_i) w_next = S_DONE;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign rdata_o = r_rdata;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, loads, extension, misalignment,
// handshake delays and reset during an outstanding access.
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  func3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misaligned_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;

    lsu dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .lsu_req_i    (lsu_req_i),
        .lsu_we_i     (lsu_we_i),
        .func3_i      (func3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .misaligned_o (misaligned_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (done_o === 1'b1) n_done++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with the DUT idle.
    task automatic run_acc(input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int gd,
                           input int rvd, input logic [3:0] ebe,
                           input logic [31:0] ewd);
        lsu_req_i = 1'b1;
        lsu_we_i  = we;
        func3_i   = f3;
        addr_i    = a;
        wdata_i   = wd;
        @(negedge clk_i);
        chk("accept_stall", {31'd0, stall_o}, 32'd1);
        chk("accept_noreq", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk_i); #1;
        for (int i = 0; i <= gd; i++) begin
            mem_gnt_i = (i == gd);
            @(negedge clk_i);
            chk("req_valid", {31'd0, mem_req_o}, 32'd1);
            chk("req_stall", {31'd0, stall_o}, 32'd1);
            chk("req_we", {31'd0, mem_we_o}, {31'd0, we});
            chk("req_addr", mem_addr_o, a & 32'hFFFF_FFFC);
            chk("req_be", {28'd0, mem_be_o}, {28'd0, ebe});
            if (we) chk("req_wdata", mem_wdata_o, ewd);
            @(posedge clk_i); #1;
        end
        mem_gnt_i = 1'b0;
        for (int i = 0; i <= rvd; i++) begin
            mem_rvalid_i = (i == rvd);
            mem_rdata_i  = rd;
            @(negedge clk_i);
            chk("wait_stall", {31'd0, stall_o}, 32'd1);
            chk("wait_noreq", {31'd0, mem_req_o}, 32'd0);
            chk("wait_nodone", {31'd0, done_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        @(negedge clk_i);
        chk("done_pulse", {31'd0, done_o}, 32'd1);
        chk("done_nostall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        chk("done_once", {31'd0, done_o}, 32'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        rst_i        = 1'b1;
        lsu_req_i    = 1'b0;
        lsu_we_i     = 1'b0;
        func3_i      = 3'd0;
        addr_i       = 32'h0;
        wdata_i      = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_mreq", {31'd0, mem_req_o}, 32'd0);
        chk("rst_maddr", mem_addr_o, 32'h0);
        chk("rst_mbe", {28'd0, mem_be_o}, 32'h0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        run_acc(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0,
                4'b1111, 32'hDEADBEEF);
        run_acc(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0,
                4'b1111, 32'h0);
        chk("lw_rdata", rdata_o, 32'hDEADBEEF);

        run_acc(1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h0, 0, 0,
                4'b1000, 32'hABABABAB);
        run_acc(1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 0, 0,
                4'b1100, 32'h12341234);
        chk("store_keeps_rdata", rdata_o, 32'hDEADBEEF);

        run_acc(1'b0, 3'b000, 32'h101, 32'h0, 32'h00008000, 0, 0,
                4'b1111, 32'h0);
        chk("lb_rdata", rdata_o, 32'hFFFFFF80);
        run_acc(1'b0, 3'b100, 32'h101, 32'h0, 32'h00008000, 0, 0,
                4'b1111, 32'h0);
        chk("lbu_rdata", rdata_o, 32'h00000080);
        run_acc(1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 0, 0,
                4'b1111, 32'h0);
        chk("lh_rdata", rdata_o, 32'hFFFF8001);
        run_acc(1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 0, 0,
                4'b1111, 32'h0);
        chk("lhu_rdata", rdata_o, 32'h00008001);

        // Illegal requests: LH odd, LW half-aligned, load funct3=3.
        lsu_req_i = 1'b1;
        lsu_we_i  = 1'b0;
        func3_i   = 3'b001;
        addr_i    = 32'h101;
        @(negedge clk_i);
        chk("lh_mis_flag", {31'd0, misaligned_o}, 32'd1);
        chk("lh_mis_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        func3_i = 3'b010;
        addr_i  = 32'h102;
        @(negedge clk_i);
        chk("lw_mis_flag", {31'd0, misaligned_o}, 32'd1);
        chk("lw_mis_noreq", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk_i); #1;
        func3_i = 3'b011;
        addr_i  = 32'h100;
        @(negedge clk_i);
        chk("f3_mis_flag", {31'd0, misaligned_o}, 32'd1);
        chk("f3_mis_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        chk("mis_after_noreq", {31'd0, mem_req_o}, 32'd0);
        chk("mis_clear", {31'd0, misaligned_o}, 32'd0);
        @(posedge clk_i); #1;

        // Delayed grant (3 cycles) and response (2 cycles after grant).
        run_acc(1'b1, 3'b010, 32'h200, 32'h55AA55AA, 32'h0, 3, 1,
                4'b1111, 32'h55AA55AA);

        // Reset while waiting for the response.
        lsu_req_i = 1'b1;
        lsu_we_i  = 1'b0;
        func3_i   = 3'b010;
        addr_i    = 32'h300;
        @(posedge clk_i); #1;
        mem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        mem_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_wait", {31'd0, stall_o}, 32'd1);
        rst_i     = 1'b1;
        lsu_req_i = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
        chk("mid_rst_mreq", {31'd0, mem_req_o}, 32'd0);
        chk("mid_rst_rdata", rdata_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i        = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0BAD0;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("stray_rv_nodone", {31'd0, done_o}, 32'd0);
        chk("stray_rv_rdata", rdata_o, 32'h0);
        @(posedge clk_i); #1;

        run_acc(1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 0, 0,
                4'b1111, 32'h0);
        chk("post_rst_lw", rdata_o, 32'h12345678);

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("done_count", n_done, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the single-cycle core's datapath (ALU result as address, register-file read data as store data) and a handshaked data memory. It converts RV32I load/store instructions into word-aligned memory transactions with byte enables, and sign/zero-extends load data for register write-back. It stalls the core until each access completes.

## Interface
- DW, 32, data and address width (only 32 supported)
- BEW, DW/8, byte-enable width
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- lsu_req_i  in  1  current instruction is a load/store; held high by the core while stall_o=1
- lsu_we_i  in  1  1 = store, 0 = load
- func3_i  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- addr_i  in  DW  effective byte address (ALU result)
- wdata_i  in  DW  store data (rs2)
- stall_o  out  1  freeze PC and register-file write
- done_o  out  1  one-cycle pulse: access complete, rdata_o valid for loads
- rdata_o  out  DW  extended load data
- misaligned_o  out  1  misaligned or illegal funct3 request; no access issued
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  memory write
- mem_addr_o  out  DW  word address, bits [1:0] always 0
- mem_wdata_o  out  DW  lane-replicated store data
- mem_be_o  out  BEW  byte enables
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  response valid (read data or write ack)
- mem_rdata_i  in  DW  read word

## Operation
- FSM states IDLE, REQ, WAIT, DONE.
- IDLE: if lsu_req_i and legal/aligned, register we, func3, addr, wdata -> REQ. If lsu_req_i and illegal, misaligned_o=1 (combinational), stay IDLE, no memory access, no stall.
- Legal: loads func3 in {0,1,2,4,5}; stores in {0,1,2}. Halfword requires addr[0]=0; word requires addr[1:0]=0.
- REQ: mem_req_o=1 with stable mem_we_o/addr/wdata/be until mem_gnt_i=1 -> WAIT.
- WAIT: on mem_rvalid_i=1 -> DONE; for loads, register extracted data into rdata_o.
- DONE: done_o=1, stall_o=0; lsu_req_i ignored this cycle (it belongs to the completed instruction) -> IDLE.
- Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b1111.
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load extraction selects byte/half lane by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
- mem_gnt_i outside REQ and mem_rvalid_i outside WAIT are ignored.
- One outstanding access maximum.

## Timing
- stall_o = (IDLE & lsu_req_i & legal) | REQ | WAIT; combinational.
- Minimum latency (gnt in first REQ cycle, rvalid the next cycle): accept in cycle 0, REQ cycle 1, WAIT cycle 2, done_o in cycle 3; stall_o high in cycles 0-2.
- Each gnt wait cycle and each rvalid wait cycle adds one cycle.
- rvalid is never earlier than the cycle after gnt.
- rdata_o holds its value until the next load's completion. Stores leave rdata_o unchanged.
- Reset values: state IDLE; stall_o 0 (with lsu_req_i=0), done_o 0, rdata_o 0, misaligned_o 0, mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, mem_be_o 0.
- Reset mid-access (REQ/WAIT): immediately returns to IDLE and drops mem_req_o. A later stray mem_rvalid_i is ignored and done_o stays 0.

## Test plan
- SW addr 0x100 wdata 0xDEADBEEF, gnt and rvalid immediate: mem_be_o=1111, mem_addr_o=0x100, stall_o 3 cycles, done_o in cycle 3. Then LW 0x100 with mem_rdata 0xDEADBEEF gives rdata_o=0xDEADBEEF.
- SB addr 0x103 wdata 0x000000AB: mem_addr_o=0x100, mem_be_o=1000, mem_wdata_o=0xABABABAB. SH addr 0x102 wdata 0x1234 gives mem_be_o=1100, mem_wdata_o=0x12341234.
- LB addr 0x101, mem_rdata 0x00008000 -> rdata_o=0xFFFFFF80. LBU -> 0x00000080. LH addr 0x102, mem_rdata 0x80010000 -> 0xFFFF8001. LHU -> 0x00008001.
- LH addr 0x101 or LW addr 0x102, or load func3=3: misaligned_o=1 same cycle, stall_o=0, mem_req_o never asserts.
- mem_gnt_i delayed 3 cycles and rvalid 2 cycles after gnt: mem_req_o and its payload stay stable for 4 cycles, stall_o continuous until done_o, exactly one done_o pulse.
- Assert rst_i while in WAIT, then pulse mem_rvalid_i: all outputs at reset values, done_o stays 0, the next request proceeds normally.
